// File: rtl/tdm8_pkg.sv
// Shared frame geometry, shadow-bank types and the frame packing helper for the TDM8 serializer.
package tdm8_pkg;

  localparam int SLOTS       = 8;
  localparam int DATA_W      = 24;
  localparam int SLOT_W      = 32;
  localparam int FRAME_W     = SLOTS * SLOT_W;
  localparam int BITCNT_W    = $clog2(FRAME_W);
  localparam int USER_W      = 4;
  localparam int SYNC_STAGES = 2;

  typedef logic [DATA_W-1:0] slot_word_t;
  typedef slot_word_t [SLOTS-1:0] shadow_bank_t;

  // Slot 0 lands in the frame MSBs; user bits occupy slot 7 bits 24..27.
  function automatic logic [FRAME_W-1:0] pack_frame(input shadow_bank_t bank,
                                                     input logic [USER_W-1:0] usr);
    logic [FRAME_W-1:0] f;
    f = '0;
    for (int s = 0; s < SLOTS; s++) begin
      f[FRAME_W-1-s*SLOT_W -: DATA_W] = bank[s];
    end
    f[SLOT_W-DATA_W-1 -: USER_W] = usr;
    return f;
  endfunction

endpackage

// File: rtl/wc_edge_sync.sv
// Synchronises an asynchronous frame clock into the local domain and emits a
// one-cycle registered pulse on each rising edge.
module wc_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_rise;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
      r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/tdm8_serializer.sv
// Serialises eight 24-bit words per word clock into a 256-bit TDM8 DSP-mode frame.
// Optional build macro TDM8_USER_BITS_EN carries the user nibble in slot 7 pad bits.
module tdm8_serializer
  import tdm8_pkg::*;
(
  input  logic              mclk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              wordclock,
  input  logic [DATA_W-1:0] word0,
  input  logic [DATA_W-1:0] word1,
  input  logic [DATA_W-1:0] word2,
  input  logic [DATA_W-1:0] word3,
  input  logic [DATA_W-1:0] word4,
  input  logic [DATA_W-1:0] word5,
  input  logic [DATA_W-1:0] word6,
  input  logic [DATA_W-1:0] word7,
  input  logic [USER_W-1:0] user,
  output logic              sdata,
  output logic              fsync,
  output logic              locked,
  output logic              frame_err
);

  logic                 w_wd_rise;
  shadow_bank_t         w_in_bank;
  shadow_bank_t         w_src_bank;
  logic [USER_W-1:0]    w_src_user;
  logic [FRAME_W-1:0]   w_frame;
  logic                 w_frame_end;
  logic                 w_start;
  logic                 w_missing;
  logic                 w_early;
  logic                 w_ontime;

  shadow_bank_t         r_shadow;
  logic                 r_pending;
  logic                 r_active;
  logic [BITCNT_W-1:0]  r_bitcnt;
  logic [FRAME_W-2:0]   r_shift;
  logic                 r_sdata;
  logic                 r_fsync;
  logic                 r_err;
  logic [1:0]           r_good;

  wc_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wc_edge_sync (
    .i_clk   (mclk),
    .i_rst   (rst),
    .i_async (wordclock),
    .o_rise  (w_wd_rise)
  );

  assign w_in_bank = {word7, word6, word5, word4, word3, word2, word1, word0};

`ifdef TDM8_USER_BITS_EN
  logic [USER_W-1:0] r_user;

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_user <= '0;
    end else if (w_wd_rise) begin
      r_user <= user;
    end
  end

  assign w_src_user = w_wd_rise ? user : r_user;
`else
  logic w_unused_user;
  assign w_unused_user = ^user;
  assign w_src_user    = '0;
`endif

  // A start coinciding with wd_rise takes the live inputs, since the shadow is only just loading.
  assign w_src_bank  = w_wd_rise ? w_in_bank : r_shadow;
  assign w_frame     = pack_frame(w_src_bank, w_src_user);
  assign w_frame_end = &r_bitcnt;
  assign w_start     = bit_en & (r_pending | w_wd_rise);
  assign w_missing   = bit_en & ~w_start & r_active & w_frame_end;
  assign w_early     = w_wd_rise & r_active & ~w_frame_end & ~r_pending;
  assign w_ontime    = w_start & r_active & w_frame_end;

  always_ff @(posedge mclk) begin
    if (rst) begin
      r_shadow  <= '0;
      r_pending <= 1'b0;
      r_active  <= 1'b0;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_sdata   <= 1'b0;
      r_fsync   <= 1'b0;
      r_err     <= 1'b0;
      r_good    <= 2'd0;
    end else begin
      r_err <= w_early | w_missing;

      if (w_wd_rise) begin
        r_shadow <= w_in_bank;
      end

      if (w_start) begin
        r_pending <= 1'b0;
      end else if (w_wd_rise) begin
        r_pending <= 1'b1;
      end

      // A missing edge lets the drained shift register run on, giving an all-zero frame.
      if (w_start) begin
        r_active <= 1'b1;
        r_bitcnt <= '0;
        r_shift  <= w_frame[FRAME_W-2:0];
        r_sdata  <= w_frame[FRAME_W-1];
        r_fsync  <= 1'b1;
      end else if (bit_en) begin
        r_bitcnt <= r_bitcnt + BITCNT_W'(1);
        r_shift  <= {r_shift[FRAME_W-3:0], 1'b0};
        r_sdata  <= r_shift[FRAME_W-2];
        r_fsync  <= w_missing;
      end

      if (w_early | w_missing) begin
        r_good <= 2'd0;
      end else if (w_ontime && (r_good != 2'd2)) begin
        r_good <= r_good + 2'd1;
      end
    end
  end

  assign sdata     = r_sdata;
  assign fsync     = r_fsync;
  assign frame_err = r_err;
  assign locked    = (r_good == 2'd2);

endmodule
